cacheline_adaptor_param: RTL and testbench
==========================================

Name: cacheline_adaptor_param

Overview:
Parametrised successor to the fixed 256/64-bit cacheline adaptor. It bridges the last-level cache (one full line per request) to DRAM (fixed-length bursts of BURST_W-bit beats). It latches the request address and write data at acceptance and drives a line-aligned address. It serialises and deserialises lines of any width that is a whole multiple of the beat width, and returns a single-cycle completion pulse.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, DRAM beat width in bits. LINE_W % BURST_W == 0. BEATS = LINE_W/BURST_W must be a power of two and >= 2.
- ADDR_W, 32, address width in bits.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with ADAPTOR_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- line_i  in  LINE_W  write line from LLC.
- line_o  out  LINE_W  read line to LLC.
- address_i  in  ADDR_W  request address.
- read_i  in  1  LLC read request, level.
- write_i  in  1  LLC write request, level.
- resp_o  out  1  completion pulse to LLC.
- err_o  out  1  timeout error pulse, coincident with resp_o.
- burst_i  in  BURST_W  DRAM read beat.
- burst_o  out  BURST_W  DRAM write beat.
- address_o  out  ADDR_W  line-aligned DRAM address.
- read_o  out  1  DRAM read request.
- write_o  out  1  DRAM write request.
- resp_i  in  1  DRAM beat-valid / beat-accepted strobe.

Behaviour:
- Reset:
  - state = IDLE, beat count = 0.
  - read_o, write_o, resp_o, err_o = 0.
  - address_o = 0, line_o = 0, write buffer = 0.
  - Reset mid-transaction aborts it silently; no resp_o is issued for the aborted transaction.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1: latch address_o = address_i with the low log2(LINE_W/8) bits cleared. read_o <= 1. Go to READ.
  - write_i=1 and read_i=0: latch address_o the same way and the write buffer = line_i. write_o <= 1. Go to WRITE.
  - Both asserted: read wins. write_i stays pending and is accepted after the read completes, if still held.
- READ:
  - Each cycle with resp_i=1: line_o[cnt*BURST_W +: BURST_W] <= burst_i, then cnt++.
  - On the resp_i of beat BEATS-1: read_o <= 0, cnt <= 0, go to DONE.
  - line_o is updated only in READ. It holds its value until the next read.
- WRITE:
  - burst_o = write_buffer[cnt*BURST_W +: BURST_W], combinational from the registered buffer and counter.
  - Each resp_i=1: cnt++. The last beat drops write_o and goes to DONE.
  - burst_o is don't-care outside WRITE but must be deterministic (beat indexed by cnt).
- DONE:
  - resp_o = 1 for exactly one cycle, then return to IDLE.
  - The LLC must deassert read_i/write_i in the cycle after resp_o. The adaptor re-samples them in IDLE.
- Request inputs, line_i and address_i are ignored outside IDLE. Changing them mid-transaction has no effect.
- All outputs are registered except burst_o.
- Latency: with request accepted in cycle T and resp_i=1 every cycle from T+1, the last beat is at T+BEATS and resp_o is at T+BEATS+1.
- Beat counter width: log2(BEATS). Wrap-around is prevented by the last-beat transition.

Optional Feature:
- ADAPTOR_TIMEOUT_EN defined:
  - A counter tracks consecutive cycles in READ/WRITE with resp_i=0 and is cleared on each resp_i.
  - When it reaches TIMEOUT_CYCLES: drop read_o/write_o, clear cnt, go to DONE, and pulse err_o together with resp_o.
  - line_o keeps any partially filled beats.
- Not defined: no counter logic; err_o is tied to 0.

Decomposition:
- cacheline_adaptor_pkg holds:
  - the state enum (IDLE/READ/WRITE/DONE);
  - the function beats(LINE_W, BURST_W);
  - the line-offset-bits constant helper.
- No sub-module is required. The beat mux/demux stays inline as indexed part-selects.

Test Plan:
- Defaults; read_i with address_i=0x0000_1234; resp_i high 4 cycles with beats A0..A3 -> address_o=0x0000_1220, read_o high 4 cycles, line_o={A3,A2,A1,A0}, resp_o one pulse at accept+5.
- Write line_i=256'h4444..._3333..._2222..._1111... with resp_i gaps of 2 cycles -> burst_o sequence 1111...,2222...,3333...,4444..., write_o drops after the 4th resp_i, single resp_o.
- read_i and write_i both high in IDLE -> read executes first; write executes next if write_i still held after resp_o.
- LINE_W=512, BURST_W=128 -> 4 beats, line assembled correctly, address low 6 bits cleared.
- reset asserted after beat 2 of a read -> next cycle read_o=0, resp_o never pulses, state IDLE.
- With ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16, resp_i held low -> read_o drops and resp_o and err_o pulse 16 cycles after the last activity.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constant helpers for the parametrised LLC <-> DRAM cacheline adaptor.
package cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of DRAM beats needed to move one cacheline.
  function automatic int unsigned beats(input int unsigned line_w, input int unsigned burst_w);
    return line_w / burst_w;
  endfunction

  // Byte-offset bits inside a line; these are cleared to form the DRAM address.
  function automatic int unsigned line_offset_bits(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/cacheline_adaptor_param.sv
// Cacheline adaptor: one LLC line request <-> a fixed-length burst of DRAM beats.
// Optional watchdog enabled by defining ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor_param
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W         = 256,
  parameter int unsigned BURST_W        = 64,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  output logic              err_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int unsigned BEATS = beats(LINE_W, BURST_W);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = line_offset_bits(LINE_W);

  // Reject illegal geometries at elaboration time.
  if ((LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0 ||
      TIMEOUT_CYCLES == 0 || OFF_W >= ADDR_W) begin : g_bad_params
    $error("cacheline_adaptor_param: illegal parameter combination");
  end

  state_e              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [LINE_W-1:0]   wbuf, wbuf_d;
  logic [LINE_W-1:0]   line_d;
  logic [ADDR_W-1:0]   address_d;
  logic [ADDR_W-1:0]   aligned_addr_c;
  logic                read_d, write_d, resp_d;
  logic                last_beat_c;
  logic                timeout_c;

  assign aligned_addr_c = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign last_beat_c    = (cnt == CNT_W'(BEATS - 1));

  // Write beat mux: combinational from the registered buffer and beat counter.
  assign burst_o = wbuf[int'(cnt) * BURST_W +: BURST_W];

`ifdef ADAPTOR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_cnt, stall_cnt_d;

  // Consecutive stalled cycles in a burst; fires on the TIMEOUT_CYCLES-th one.
  always_comb begin
    stall_cnt_d = '0;
    timeout_c   = 1'b0;
    if ((state == READ || state == WRITE) && !resp_i) begin
      if (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_c = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err_o     <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_d;
      err_o     <= timeout_c;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    read_d    = read_o;
    write_d   = write_o;
    address_d = address_o;
    line_d    = line_o;
    wbuf_d    = wbuf;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (read_i) begin
          address_d = aligned_addr_c;
          read_d    = 1'b1;
          state_d   = READ;
        end else if (write_i) begin
          address_d = aligned_addr_c;
          wbuf_d    = line_i;
          write_d   = 1'b1;
          state_d   = WRITE;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[int'(cnt) * BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt + 1'b1;
          if (last_beat_c) begin
            cnt_d   = '0;
            read_d  = 1'b0;
            state_d = DONE;
          end
        end else if (timeout_c) begin
          cnt_d   = '0;
          read_d  = 1'b0;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt + 1'b1;
          if (last_beat_c) begin
            cnt_d   = '0;
            write_d = 1'b0;
            state_d = DONE;
          end
        end else if (timeout_c) begin
          cnt_d   = '0;
          write_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
    // resp_o is high for exactly the single cycle spent in DONE.
    resp_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      line_o    <= '0;
      wbuf      <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      read_o    <= read_d;
      write_o   <= write_d;
      resp_o    <= resp_d;
      address_o <= address_d;
      line_o    <= line_d;
      wbuf      <= wbuf_d;
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor_param.sv
// Directed self-checking bench for cacheline_adaptor_param (256/64 and 512/128 instances).
module tb_cacheline_adaptor_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 256/64 instance
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, err_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;

  cacheline_adaptor_param #(
    .LINE_W(256), .BURST_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o), .err_o(err_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  // 512/128 instance
  logic [511:0] w_line_i, w_line_o;
  logic [31:0]  w_address_i, w_address_o;
  logic         w_read_i, w_write_i, w_resp_o, w_err_o, w_read_o, w_write_o, w_resp_i;
  logic [127:0] w_burst_i, w_burst_o;

  cacheline_adaptor_param #(
    .LINE_W(512), .BURST_W(128), .ADDR_W(32), .TIMEOUT_CYCLES(1024)
  ) dut_wide (
    .clk(clk), .reset(reset), .line_i(w_line_i), .line_o(w_line_o),
    .address_i(w_address_i), .read_i(w_read_i), .write_i(w_write_i),
    .resp_o(w_resp_o), .err_o(w_err_o), .burst_i(w_burst_i), .burst_o(w_burst_o),
    .address_o(w_address_o), .read_o(w_read_o), .write_o(w_write_o), .resp_i(w_resp_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL reset_read_o got=%b exp=0", read_o); end
    checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL reset_write_o got=%b exp=0", write_o); end
    checks++; if (resp_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b%b exp=00", resp_o, err_o); end
    checks++; if (address_o !== 32'h0) begin errors++; $display("FAIL reset_address_o got=%h exp=0", address_o); end
    checks++; if (line_o !== 256'h0) begin errors++; $display("FAIL reset_line_o got=%h exp=0", line_o); end
    checks++; if (burst_o !== 64'h0) begin errors++; $display("FAIL reset_burst_o got=%h exp=0", burst_o); end
  endtask

  task automatic test_read();
    logic [63:0]  a [4];
    logic [255:0] exp_line;
    a[0] = 64'hA0A0_0000_0000_00A0; a[1] = 64'hA1A1_1111_1111_11A1;
    a[2] = 64'hA2A2_2222_2222_22A2; a[3] = 64'hA3A3_3333_3333_33A3;
    exp_line = {a[3], a[2], a[1], a[0]};
    address_i = 32'h0000_1234;
    read_i = 1'b1;
    tick();
    checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL read_accept got=%b exp=1", read_o); end
    checks++; if (address_o !== 32'h0000_1220) begin errors++; $display("FAIL read_addr got=%h exp=00001220", address_o); end
    address_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      burst_i = a[k];
      tick();
      checks++;
      if (read_o !== (k < 3) || resp_o !== (k == 3)) begin
        errors++; $display("FAIL read_beat%0d read_o/resp_o got=%b%b exp=%b%b", k, read_o, resp_o, k < 3, k == 3);
      end
    end
    resp_i = 1'b0;
    burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    read_i = 1'b0;
    checks++; if (line_o !== exp_line) begin errors++; $display("FAIL read_line got=%h exp=%h", line_o, exp_line); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", err_o); end
    checks++; if (address_o !== 32'h0000_1220) begin errors++; $display("FAIL read_addr_hold got=%h exp=00001220", address_o); end
    tick();
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL read_resp_single got=%b exp=0", resp_o); end
    tick();
    checks++; if (line_o !== exp_line || read_o !== 1'b0) begin errors++; $display("FAIL read_hold line=%h read_o=%b", line_o, read_o); end
  endtask

  task automatic test_write();
    logic [63:0] b [4];
    b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
    b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
    line_i = {b[3], b[2], b[1], b[0]};
    address_i = 32'h0000_ABCD;
    write_i = 1'b1;
    tick();
    checks++; if (write_o !== 1'b1 || read_o !== 1'b0) begin errors++; $display("FAIL write_accept got w=%b r=%b exp w=1 r=0", write_o, read_o); end
    checks++; if (address_o !== 32'h0000_ABC0) begin errors++; $display("FAIL write_addr got=%h exp=0000abc0", address_o); end
    line_i = '1;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 2; g++) begin
        resp_i = 1'b0;
        checks++; if (burst_o !== b[k]) begin errors++; $display("FAIL write_burst%0d got=%h exp=%h", k, burst_o, b[k]); end
        tick();
        checks++; if (write_o !== 1'b1 || resp_o !== 1'b0) begin errors++; $display("FAIL write_gap%0d w=%b resp=%b exp w=1 resp=0", k, write_o, resp_o); end
      end
      resp_i = 1'b1;
      checks++; if (burst_o !== b[k]) begin errors++; $display("FAIL write_burst_ack%0d got=%h exp=%h", k, burst_o, b[k]); end
      tick();
    end
    resp_i = 1'b0;
    write_i = 1'b0;
    checks++; if (write_o !== 1'b0 || resp_o !== 1'b1) begin errors++; $display("FAIL write_done w=%b resp=%b exp w=0 resp=1", write_o, resp_o); end
    tick();
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL write_resp_single got=%b exp=0", resp_o); end
  endtask

  task automatic test_priority();
    logic [63:0]  a [4];
    logic [63:0]  b [4];
    logic [255:0] exp_line;
    for (int k = 0; k < 4; k++) begin
      a[k] = 64'h5A5A_0000_0000_0000 + 64'(k);
      b[k] = 64'hC3C3_0000_0000_0000 + 64'(k);
    end
    exp_line = {a[3], a[2], a[1], a[0]};
    line_i = {b[3], b[2], b[1], b[0]};
    address_i = 32'h0000_0100;
    read_i = 1'b1;
    write_i = 1'b1;
    tick();
    checks++; if (read_o !== 1'b1 || write_o !== 1'b0) begin errors++; $display("FAIL prio_read_first r=%b w=%b exp r=1 w=0", read_o, write_o); end
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      burst_i = a[k];
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    checks++; if (resp_o !== 1'b1 || line_o !== exp_line) begin errors++; $display("FAIL prio_read_done resp=%b line=%h", resp_o, line_o); end
    tick();
    checks++; if (write_o !== 1'b0 || resp_o !== 1'b0) begin errors++; $display("FAIL prio_gap w=%b resp=%b exp 0 0", write_o, resp_o); end
    tick();
    checks++; if (write_o !== 1'b1 || burst_o !== b[0]) begin errors++; $display("FAIL prio_write_accept w=%b burst=%h exp w=1 burst=%h", write_o, burst_o, b[0]); end
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      checks++; if (burst_o !== b[k]) begin errors++; $display("FAIL prio_write_burst%0d got=%h exp=%h", k, burst_o, b[k]); end
      tick();
    end
    resp_i = 1'b0;
    write_i = 1'b0;
    checks++; if (resp_o !== 1'b1 || write_o !== 1'b0) begin errors++; $display("FAIL prio_write_done resp=%b w=%b exp 1 0", resp_o, write_o); end
    checks++; if (line_o !== exp_line) begin errors++; $display("FAIL prio_line_hold got=%h exp=%h", line_o, exp_line); end
    tick();
  endtask

  task automatic test_wide();
    logic [127:0] a [4];
    logic [511:0] exp_line;
    a[0] = 128'h0000_0000_0000_0000_0000_0000_0000_00F0;
    a[1] = 128'h1111_1111_1111_1111_1111_1111_1111_11F1;
    a[2] = 128'h2222_2222_2222_2222_2222_2222_2222_22F2;
    a[3] = 128'h3333_3333_3333_3333_3333_3333_3333_33F3;
    exp_line = {a[3], a[2], a[1], a[0]};
    w_address_i = 32'h0000_1234;
    w_read_i = 1'b1;
    tick();
    checks++; if (w_address_o !== 32'h0000_1200 || w_read_o !== 1'b1) begin errors++; $display("FAIL wide_accept addr=%h r=%b exp 00001200 1", w_address_o, w_read_o); end
    for (int k = 0; k < 4; k++) begin
      w_resp_i = 1'b1;
      w_burst_i = a[k];
      tick();
    end
    w_resp_i = 1'b0;
    w_read_i = 1'b0;
    checks++; if (w_resp_o !== 1'b1 || w_read_o !== 1'b0) begin errors++; $display("FAIL wide_done resp=%b r=%b exp 1 0", w_resp_o, w_read_o); end
    checks++; if (w_line_o !== exp_line) begin errors++; $display("FAIL wide_line got=%h exp=%h", w_line_o, exp_line); end
    tick();
    checks++; if (w_resp_o !== 1'b0 || w_err_o !== 1'b0) begin errors++; $display("FAIL wide_resp_single resp=%b err=%b", w_resp_o, w_err_o); end
  endtask

  task automatic test_reset_abort();
    int resp_seen;
    address_i = 32'h0000_2040;
    read_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1;
      burst_i = 64'h7777_0000_0000_0000 + 64'(k);
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (read_o !== 1'b0 || resp_o !== 1'b0) begin errors++; $display("FAIL abort_outputs r=%b resp=%b exp 0 0", read_o, resp_o); end
    checks++; if (line_o !== 256'h0 || address_o !== 32'h0) begin errors++; $display("FAIL abort_cleared line=%h addr=%h exp 0", line_o, address_o); end
    resp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      resp_i = 1'b1;
      tick();
      if (resp_o === 1'b1 || read_o === 1'b1) resp_seen++;
    end
    resp_i = 1'b0;
    checks++; if (resp_seen !== 0) begin errors++; $display("FAIL abort_no_resp got=%0d active cycles exp=0", resp_seen); end
    // Idle adaptor must take a fresh read immediately.
    address_i = 32'h0000_3000;
    read_i = 1'b1;
    tick();
    checks++; if (read_o !== 1'b1 || address_o !== 32'h0000_3000) begin errors++; $display("FAIL abort_restart r=%b addr=%h exp 1 00003000", read_o, address_o); end
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      burst_i = 64'h0;
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL abort_restart_done resp=%b exp 1", resp_o); end
    tick();
  endtask

`ifdef ADAPTOR_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    address_i = 32'h0000_4444;
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    resp_i = 1'b0;
    early = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (resp_o !== 1'b0 || err_o !== 1'b0 || read_o !== 1'b1) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early got=%0d bad cycles exp=0", early); end
    tick();
    checks++; if (resp_o !== 1'b1 || err_o !== 1'b1 || read_o !== 1'b0) begin errors++; $display("FAIL timeout_fire resp=%b err=%b r=%b exp 1 1 0", resp_o, err_o, read_o); end
    tick();
    checks++; if (resp_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL timeout_single resp=%b err=%b exp 0 0", resp_o, err_o); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0; burst_i = '0;
    w_line_i = '0; w_address_i = '0; w_read_i = 1'b0; w_write_i = 1'b0; w_resp_i = 1'b0; w_burst_i = '0;
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_wide();
    test_reset_abort();
`ifdef ADAPTOR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
